// File: rtl/lc3b_types.sv
// Shared types and direction-counter encodings for the fetch-PC / BTB slice.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  // Counter values are returned wide; callers cast to their CTR_BITS width.
  function automatic int unsigned weak_taken(input int unsigned ctr_bits);
    return 32'd1 << (ctr_bits - 1);
  endfunction

  function automatic int unsigned weak_not_taken(input int unsigned ctr_bits);
    return (32'd1 << (ctr_bits - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/pc_btb_unit_btb_array.sv
// Direct-mapped branch target buffer: valid/tag/target/counter storage with a
// combinational lookup port and a training port using saturating counters.
module btb_array
  import lc3b_types::*;
#(
  parameter int WIDTH       = 16,
  parameter int BTB_ENTRIES = 16,
  parameter int CTR_BITS    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] lookup_addr,
  output logic             hit,
  output logic             taken,
  output logic [WIDTH-1:0] target,
  input  logic             update_valid,
  input  logic [WIDTH-1:0] update_addr,
  input  logic [WIDTH-1:0] update_target,
  input  logic             update_taken
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = WIDTH - IDX_W - 1;
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(weak_taken(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'(weak_not_taken(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  logic                valid   [BTB_ENTRIES];
  logic [CTR_BITS-1:0] ctrs    [BTB_ENTRIES];
  logic [TAG_W-1:0]    tags    [BTB_ENTRIES];
  logic [WIDTH-1:0]    targets [BTB_ENTRIES];

  logic [IDX_W-1:0]    lookup_idx, upd_idx;
  logic [TAG_W-1:0]    lookup_tag, upd_tag;
  logic                upd_hit, write_en;
  logic [CTR_BITS-1:0] next_ctr;
  logic                unused_align;

  // Instructions are halfword aligned, so address bit 0 never selects anything.
  assign lookup_idx   = lookup_addr[IDX_W:1];
  assign lookup_tag   = lookup_addr[WIDTH-1:IDX_W+1];
  assign upd_idx      = update_addr[IDX_W:1];
  assign upd_tag      = update_addr[WIDTH-1:IDX_W+1];
  assign unused_align = lookup_addr[0] ^ update_addr[0];

  assign upd_hit  = valid[upd_idx] && (tags[upd_idx] == upd_tag);
  assign write_en = update_valid && (upd_hit || update_taken);

  always_comb begin
    hit    = valid[lookup_idx] && (tags[lookup_idx] == lookup_tag);
    taken  = hit && ctrs[lookup_idx][CTR_BITS-1];
    target = hit ? targets[lookup_idx] : '0;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_ctr = ctrs[upd_idx];
    if (!upd_hit) begin
      next_ctr = CTR_WT;
    end else if (update_taken) begin
      if (ctrs[upd_idx] != CTR_MAX) next_ctr = ctrs[upd_idx] + 1'b1;
    end else begin
      if (ctrs[upd_idx] != '0) next_ctr = ctrs[upd_idx] - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid[i] <= 1'b0;
        ctrs[i]  <= CTR_WNT;
      end
    end else if (write_en) begin
      valid[upd_idx] <= 1'b1;
      ctrs[upd_idx]  <= next_ctr;
    end
  end

  // NOTE: tag/target storage has no reset; the cleared valid bits make its contents irrelevant.
  always_ff @(posedge clk) begin
    if (rst_n && write_en && update_taken) begin
      tags[upd_idx]    <= upd_tag;
      targets[upd_idx] <= update_target;
    end
  end

endmodule

// File: rtl/pc_btb_unit.sv
// Fetch program counter with BTB-driven taken-branch prediction and
// redirect from branch resolution.
module pc_btb_unit
  import lc3b_types::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               BTB_ENTRIES = 16,
  parameter int               CTR_BITS    = 2,
  parameter int               INSTR_BYTES = 2,
  parameter logic [WIDTH-1:0] RESET_PC    = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             update_valid,
  input  logic [WIDTH-1:0] update_pc,
  input  logic [WIDTH-1:0] update_target,
  input  logic             update_taken,
  output logic [WIDTH-1:0] pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target
);

  logic [WIDTH-1:0] next_pc;

  btb_array #(
    .WIDTH      (WIDTH),
    .BTB_ENTRIES(BTB_ENTRIES),
    .CTR_BITS   (CTR_BITS)
  ) u_btb (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_addr  (pc),
    .hit          (pred_hit),
    .taken        (pred_taken),
    .target       (pred_target),
    .update_valid (update_valid),
    .update_addr  (update_pc),
    .update_target(update_target),
    .update_taken (update_taken)
  );

  // A flush outranks a stall so a redirect is never dropped.
  always_comb begin
    next_pc = pc + WIDTH'(INSTR_BYTES);
    if (redirect_valid)  next_pc = redirect_pc;
    else if (!load)      next_pc = pc;
    else if (pred_taken) next_pc = pred_target;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= next_pc;
  end

endmodule

// File: tb/tb_pc_btb_unit.sv
// Directed bench for pc_btb_unit: each scenario step compares the fetch state
// against the expected value right after the clock edge.
module tb_pc_btb_unit;
  import lc3b_types::*;

  logic     clk = 1'b0;
  logic     rst_n, load, redirect_valid, update_valid, update_taken;
  lc3b_word redirect_pc, update_pc, update_target;
  lc3b_word pc, pred_target;
  logic     pred_hit, pred_taken;

  int checks = 0;
  int passed = 0;

  pc_btb_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (load),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .update_valid  (update_valid),
    .update_pc     (update_pc),
    .update_target (update_target),
    .update_taken  (update_taken),
    .pc            (pc),
    .pred_hit      (pred_hit),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name);
    checks++;
    if (ok) passed++;
    else
      $display("FAIL %s: got pc=%h hit=%b taken=%b tgt=%h",
               name, pc, pred_hit, pred_taken, pred_target);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic train(input lc3b_word a, input lc3b_word tg, input logic tk);
    update_valid = 1'b1; update_pc = a; update_target = tg; update_taken = tk;
  endtask

  task automatic redirect(input lc3b_word a);
    redirect_valid = 1'b1; redirect_pc = a;
  endtask

  task automatic quiet();
    update_valid = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    update_valid = 1'b0; update_pc = '0; update_target = '0; update_taken = 1'b0;

    // Reset and sequential fetch
    step();
    check({pc, pred_hit, pred_taken, pred_target} === {16'h0000, 1'b0, 1'b0, 16'h0000}, "reset");
    rst_n = 1'b1; load = 1'b1;
    step();
    check({pc, pred_hit, pred_taken, pred_target} === {16'h0002, 1'b0, 1'b0, 16'h0000}, "seq_0002");
    step();
    check({pc, pred_hit, pred_taken, pred_target} === {16'h0004, 1'b0, 1'b0, 16'h0000}, "seq_0004");
    step();
    check({pc, pred_hit, pred_taken, pred_target} === {16'h0006, 1'b0, 1'b0, 16'h0000}, "seq_0006");

    // Allocate 0x0010 -> 0x0040 and let fetch reach it
    train(16'h0010, 16'h0040, 1'b1);
    step(); quiet();
    check({pc, pred_hit, pred_taken, pred_target} === {16'h0008, 1'b0, 1'b0, 16'h0000}, "alloc_0008");
    step(); step(); step(); step();
    check({pc, pred_hit, pred_taken, pred_target} === {16'h0010, 1'b1, 1'b1, 16'h0040}, "predict_0010");
    step();
    check({pc, pred_hit, pred_taken, pred_target} === {16'h0040, 1'b0, 1'b0, 16'h0000}, "taken_0040");

    // Alias at same index, different tag
    redirect(16'h0030);
    step(); quiet();
    check({pc, pred_hit, pred_taken, pred_target} === {16'h0030, 1'b0, 1'b0, 16'h0000}, "alias_0030");
    step();
    check({pc, pred_hit, pred_taken, pred_target} === {16'h0032, 1'b0, 1'b0, 16'h0000}, "alias_next");

    // Counter hysteresis with pc held at 0x0010 (load=0 also beats pred_taken)
    redirect(16'h0010); load = 1'b0;
    step(); quiet();
    check({pc, pred_hit, pred_taken, pred_target} === {16'h0010, 1'b1, 1'b1, 16'h0040}, "hold_ctr10");
    train(16'h0010, 16'h0099, 1'b0);
    step();
    check({pc, pred_hit, pred_taken, pred_target} === {16'h0010, 1'b1, 1'b0, 16'h0040}, "nt_ctr01");
    step();
    check({pc, pred_hit, pred_taken, pred_target} === {16'h0010, 1'b1, 1'b0, 16'h0040}, "nt_ctr00");
    step();
    check({pc, pred_hit, pred_taken, pred_target} === {16'h0010, 1'b1, 1'b0, 16'h0040}, "nt_sat00");
    train(16'h0010, 16'h0050, 1'b1);
    step();
    check({pc, pred_hit, pred_taken, pred_target} === {16'h0010, 1'b1, 1'b0, 16'h0050}, "t_ctr01");
    step();
    check({pc, pred_hit, pred_taken, pred_target} === {16'h0010, 1'b1, 1'b1, 16'h0050}, "t_ctr10");
    step();
    check({pc, pred_hit, pred_taken, pred_target} === {16'h0010, 1'b1, 1'b1, 16'h0050}, "t_ctr11");
    step();
    check({pc, pred_hit, pred_taken, pred_target} === {16'h0010, 1'b1, 1'b1, 16'h0050}, "t_sat11");
    train(16'h0010, 16'h0077, 1'b0);
    step(); quiet();
    check({pc, pred_hit, pred_taken, pred_target} === {16'h0010, 1'b1, 1'b1, 16'h0050}, "nt_from11");

    // Redirect dominance over stall + prediction, with a same-cycle update
    redirect(16'h1234);
    train(16'h1236, 16'h2000, 1'b1);
    step(); quiet(); load = 1'b1;
    check({pc, pred_hit, pred_taken, pred_target} === {16'h1234, 1'b0, 1'b0, 16'h0000}, "redirect_1234");
    step();
    check({pc, pred_hit, pred_taken, pred_target} === {16'h1236, 1'b1, 1'b1, 16'h2000}, "upd_same_cyc");
    step();
    check({pc, pred_hit, pred_taken, pred_target} === {16'h2000, 1'b0, 1'b0, 16'h0000}, "taken_2000");

    // Wrap at top of address space
    redirect(16'hFFFE);
    step(); quiet();
    check({pc, pred_hit, pred_taken, pred_target} === {16'hFFFE, 1'b0, 1'b0, 16'h0000}, "at_fffe");
    step();
    check({pc, pred_hit, pred_taken, pred_target} === {16'h0000, 1'b0, 1'b0, 16'h0000}, "wrap_0000");

    // Reset together with a taken update: the update is discarded
    rst_n = 1'b0;
    train(16'h0004, 16'h0100, 1'b1);
    step(); quiet(); rst_n = 1'b1;
    check({pc, pred_hit, pred_taken, pred_target} === {16'h0000, 1'b0, 1'b0, 16'h0000}, "rst_mid_upd");
    step();
    check({pc, pred_hit, pred_taken, pred_target} === {16'h0002, 1'b0, 1'b0, 16'h0000}, "post_rst_0002");
    step();
    check({pc, pred_hit, pred_taken, pred_target} === {16'h0004, 1'b0, 1'b0, 16'h0000}, "discarded_0004");
    step();
    check({pc, pred_hit, pred_taken, pred_target} === {16'h0006, 1'b0, 1'b0, 16'h0000}, "post_rst_0006");
    redirect(16'h0010);
    step(); quiet();
    check({pc, pred_hit, pred_taken, pred_target} === {16'h0010, 1'b0, 1'b0, 16'h0000}, "cleared_0010");
    step();
    check({pc, pred_hit, pred_taken, pred_target} === {16'h0012, 1'b0, 1'b0, 16'h0000}, "cleared_next");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
